// File: rtl/wb_slave_ram.sv
// Wishbone classic single-port word RAM slave with byte lanes,
// programmable wait states, cycle abort and range/alignment errors.
module wb_slave_ram #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          DEPTH_WORDS = 1024,
    parameter int          WAIT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        rst_i,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic        wb_we_i,
    input  logic [3:0]  wb_sel_i,
    input  logic [31:0] wb_adr_i,
    input  logic [31:0] wb_dat_i,
    output logic [31:0] wb_dat_o,
    output logic        wb_ack_o,
    output logic        wb_err_o,
    output logic        wb_rty_o
);

    localparam int          AW        = $clog2(DEPTH_WORDS);
    localparam logic [32:0] SPAN      = 33'(DEPTH_WORDS) << 2;
    localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state;
    logic [3:0]  cnt;
    logic [31:0] adr_q;
    logic [31:0] dat_q;
    logic [3:0]  sel_q;
    logic        we_q;

    logic [31:0] mem [DEPTH_WORDS];

    logic          req;
    logic          enter_resp;
    logic          cur_ok;
    logic          cur_we;
    logic [3:0]    cur_sel;
    logic [31:0]   cur_adr;
    logic [31:0]   cur_dat;
    logic [31:0]   cur_off;
    logic [AW-1:0] cur_idx;

    assign wb_rty_o = 1'b0;
    assign req      = wb_cyc_i & wb_stb_i;

    // With no wait states the response is built from the live bus,
    // otherwise from the copy latched when the request was taken.
    assign cur_adr = (state == IDLE) ? wb_adr_i : adr_q;
    assign cur_dat = (state == IDLE) ? wb_dat_i : dat_q;
    assign cur_sel = (state == IDLE) ? wb_sel_i : sel_q;
    assign cur_we  = (state == IDLE) ? wb_we_i  : we_q;

    assign cur_off = cur_adr - BASE_ADDR;
    assign cur_idx = cur_off[AW+1:2];
    assign cur_ok  = (cur_adr >= BASE_ADDR)
                   && ({1'b0, cur_off} < SPAN)
                   && (cur_adr[1:0] == 2'b00);

    assign enter_resp =
        (state == IDLE && req && WAIT_CYCLES == 0) ||
        (state == WAIT && wb_cyc_i && cnt == 4'd1);

    always_ff @(posedge clk) begin
        if (enter_resp && cur_we && cur_ok && !rst_i) begin
            for (int b = 0; b < 4; b++) begin
                if (cur_sel[b]) begin
                    mem[cur_idx][8*b +: 8] <= cur_dat[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            state    <= IDLE;
            cnt      <= 4'd0;
            adr_q    <= 32'h0;
            dat_q    <= 32'h0;
            sel_q    <= 4'h0;
            we_q     <= 1'b0;
            wb_ack_o <= 1'b0;
            wb_err_o <= 1'b0;
            wb_dat_o <= 32'h0;
        end else begin
            wb_ack_o <= 1'b0;
            wb_err_o <= 1'b0;
            wb_dat_o <= 32'h0;
            unique case (state)
                IDLE: begin
                    if (req) begin
                        adr_q <= wb_adr_i;
                        dat_q <= wb_dat_i;
                        sel_q <= wb_sel_i;
                        we_q  <= wb_we_i;
                        if (WAIT_CYCLES == 0) begin
                            state <= RESP;
                        end else begin
                            state <= WAIT;
                            cnt   <= WAIT_INIT;
                        end
                    end
                end
                WAIT: begin
                    if (!wb_cyc_i) begin
                        state <= IDLE;
                        cnt   <= 4'd0;
                    end else if (cnt == 4'd1) begin
                        state <= RESP;
                        cnt   <= 4'd0;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
            if (enter_resp) begin
                wb_ack_o <= cur_ok;
                wb_err_o <= !cur_ok;
                wb_dat_o <= (cur_ok && !cur_we) ? mem[cur_idx] : 32'h0;
            end
        end
    end

endmodule

// File: tb/tb_wb_slave_ram.sv
// Directed bench for wb_slave_ram: one zero-wait and one
// three-wait-state instance driven through a shared bus.
module tb_wb_slave_ram;

    localparam logic [31:0] B0 = 32'h0000_1000;
    localparam logic [31:0] B3 = 32'h0000_2000;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        cyc0 = 1'b0, stb0 = 1'b0;
    logic        cyc3 = 1'b0, stb3 = 1'b0;
    logic        bus_we = 1'b0;
    logic [3:0]  bus_sel = 4'h0;
    logic [31:0] bus_adr = 32'h0;
    logic [31:0] bus_dat = 32'h0;
    logic [31:0] dat0, dat3;
    logic        ack0, err0, rty0;
    logic        ack3, err3, rty3;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    wb_slave_ram #(.BASE_ADDR(B0), .DEPTH_WORDS(16), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst_i(rst_i),
        .wb_cyc_i(cyc0), .wb_stb_i(stb0), .wb_we_i(bus_we),
        .wb_sel_i(bus_sel), .wb_adr_i(bus_adr), .wb_dat_i(bus_dat),
        .wb_dat_o(dat0), .wb_ack_o(ack0), .wb_err_o(err0), .wb_rty_o(rty0)
    );

    wb_slave_ram #(.BASE_ADDR(B3), .DEPTH_WORDS(16), .WAIT_CYCLES(3)) dut3 (
        .clk(clk), .rst_i(rst_i),
        .wb_cyc_i(cyc3), .wb_stb_i(stb3), .wb_we_i(bus_we),
        .wb_sel_i(bus_sel), .wb_adr_i(bus_adr), .wb_dat_i(bus_dat),
        .wb_dat_o(dat3), .wb_ack_o(ack3), .wb_err_o(err3), .wb_rty_o(rty3)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drop();
        cyc0 = 1'b0; stb0 = 1'b0;
        cyc3 = 1'b0; stb3 = 1'b0;
    endtask

    // Issues one request from cycle N; lat is the response cycle offset,
    // leak flags nonzero read data before it, extra flags any response
    // activity in the cycle after it.
    task automatic xfer(input int d, input logic we, input logic [3:0] sel,
                        input logic [31:0] adr, input logic [31:0] wdat,
                        output int lat, output logic ack, output logic err,
                        output logic [31:0] rdat, output logic leak,
                        output logic extra);
        logic a, e;
        logic [31:0] q;
        lat = -1; ack = 0; err = 0; rdat = 0; leak = 0; extra = 0;
        bus_we = we; bus_sel = sel; bus_adr = adr; bus_dat = wdat;
        if (d == 0) begin cyc0 = 1; stb0 = 1; end
        else begin cyc3 = 1; stb3 = 1; end
        for (int k = 1; k <= 10; k++) begin
            step();
            a = (d == 0) ? ack0 : ack3;
            e = (d == 0) ? err0 : err3;
            q = (d == 0) ? dat0 : dat3;
            if (lat < 0) begin
                if (a || e) begin
                    lat = k; ack = a; err = e; rdat = q;
                    drop();
                end else if (q != 32'h0) begin
                    leak = 1;
                end
            end else begin
                extra = a || e || (q != 32'h0);
                break;
            end
        end
        if (lat < 0) drop();
    endtask

    // Watches n cycles of an instance for any ack or err.
    task automatic quiet(input int d, input int n, output logic seen);
        seen = 0;
        for (int k = 0; k < n; k++) begin
            step();
            if (d == 0) seen = seen | ack0 | err0;
            else        seen = seen | ack3 | err3;
        end
    endtask

    int          lat;
    logic        ack, err, leak, extra, seen;
    logic [31:0] rdat;
    logic [4:0]  ackmask;
    logic [31:0] d1, d2;

    initial begin
        // reset values while rst_i is held
        step();
        chk("rst_ack0", {31'h0, ack0}, 32'h0);
        chk("rst_err0", {31'h0, err0}, 32'h0);
        chk("rst_dat0", dat0, 32'h0);
        chk("rst_rty0", {31'h0, rty0}, 32'h0);
        chk("rst_out3", {dat3[29:0], ack3, err3}, 32'h0);
        step();
        rst_i = 1'b0;

        // zero-wait write then read
        xfer(0, 1, 4'hF, B0 + 8, 32'hDEADBEEF, lat, ack, err, rdat, leak, extra);
        chk("w0_lat", 32'(lat), 32'd1);
        chk("w0_ack", {30'h0, ack, err}, 32'h2);
        chk("w0_dat", rdat, 32'h0);
        chk("w0_once", {31'h0, extra}, 32'h0);
        xfer(0, 0, 4'hF, B0 + 8, 32'h0, lat, ack, err, rdat, leak, extra);
        chk("r0_lat", 32'(lat), 32'd1);
        chk("r0_dat", rdat, 32'hDEADBEEF);
        chk("r0_once", {31'h0, extra}, 32'h0);

        // byte lanes, sel = 0, read ignores sel
        xfer(0, 1, 4'hF, B0 + 12, 32'h11223344, lat, ack, err, rdat, leak, extra);
        xfer(0, 1, 4'b0101, B0 + 12, 32'hAABBCCDD, lat, ack, err, rdat, leak, extra);
        chk("lane_ack", {30'h0, ack, err}, 32'h2);
        xfer(0, 0, 4'b0001, B0 + 12, 32'h0, lat, ack, err, rdat, leak, extra);
        chk("lane_rd", rdat, 32'h11BB33DD);
        xfer(0, 1, 4'h0, B0 + 12, 32'hFFFFFFFF, lat, ack, err, rdat, leak, extra);
        chk("sel0_ack", {30'h0, ack, err}, 32'h2);
        xfer(0, 0, 4'hF, B0 + 12, 32'h0, lat, ack, err, rdat, leak, extra);
        chk("sel0_rd", rdat, 32'h11BB33DD);

        // error cases against words that a wrapped index would hit
        xfer(0, 1, 4'hF, B0, 32'h01020304, lat, ack, err, rdat, leak, extra);
        xfer(0, 1, 4'hF, B0 + 60, 32'h0A0B0C0D, lat, ack, err, rdat, leak, extra);
        chk("last_ack", {30'h0, ack, err}, 32'h2);
        xfer(0, 1, 4'hF, B0 + 64, 32'hCAFEF00D, lat, ack, err, rdat, leak, extra);
        chk("e_top", {30'h0, ack, err}, 32'h1);
        chk("e_top_once", {31'h0, extra}, 32'h0);
        xfer(0, 1, 4'hF, B0 - 4, 32'hCAFEF00D, lat, ack, err, rdat, leak, extra);
        chk("e_below", {30'h0, ack, err}, 32'h1);
        xfer(0, 1, 4'hF, B0 + 2, 32'hCAFEF00D, lat, ack, err, rdat, leak, extra);
        chk("e_align", {30'h0, ack, err}, 32'h1);
        chk("e_align_lat", 32'(lat), 32'd1);
        xfer(0, 0, 4'hF, B0 + 64, 32'h0, lat, ack, err, rdat, leak, extra);
        chk("e_rd", {rdat[29:0], ack, err}, 32'h1);
        xfer(0, 0, 4'hF, B0, 32'h0, lat, ack, err, rdat, leak, extra);
        chk("e_keep0", rdat, 32'h01020304);
        xfer(0, 0, 4'hF, B0 + 60, 32'h0, lat, ack, err, rdat, leak, extra);
        chk("e_keep15", rdat, 32'h0A0B0C0D);

        // three wait states
        xfer(3, 1, 4'hF, B3 + 4, 32'h55AA55AA, lat, ack, err, rdat, leak, extra);
        chk("w3_lat", 32'(lat), 32'd4);
        chk("w3_ack", {30'h0, ack, err}, 32'h2);
        xfer(3, 0, 4'hF, B3 + 4, 32'h0, lat, ack, err, rdat, leak, extra);
        chk("r3_lat", 32'(lat), 32'd4);
        chk("r3_dat", rdat, 32'h55AA55AA);
        chk("r3_leak", {31'h0, leak}, 32'h0);
        chk("r3_once", {31'h0, extra}, 32'h0);
        xfer(3, 1, 4'hF, B3 + 64, 32'h1, lat, ack, err, rdat, leak, extra);
        chk("e3_top", {30'h0, ack, err}, 32'h1);
        chk("e3_lat", 32'(lat), 32'd4);

        // abort by dropping cyc in cycle N+2
        bus_we = 1; bus_sel = 4'hF; bus_adr = B3 + 4; bus_dat = 32'h12345678;
        cyc3 = 1; stb3 = 1;
        step();
        step();
        drop();
        quiet(3, 6, seen);
        chk("abort_quiet", {31'h0, seen}, 32'h0);
        xfer(3, 0, 4'hF, B3 + 4, 32'h0, lat, ack, err, rdat, leak, extra);
        chk("abort_keep", rdat, 32'h55AA55AA);

        // abort by reset in cycle N+2
        bus_we = 1; bus_sel = 4'hF; bus_adr = B3 + 4; bus_dat = 32'h87654321;
        cyc3 = 1; stb3 = 1;
        step();
        step();
        rst_i = 1'b1;
        #1;
        chk("rst_mid_out", {dat3[29:0], ack3, err3}, 32'h0);
        drop();
        step();
        rst_i = 1'b0;
        quiet(3, 6, seen);
        chk("rst_mid_quiet", {31'h0, seen}, 32'h0);
        xfer(3, 0, 4'hF, B3 + 4, 32'h0, lat, ack, err, rdat, leak, extra);
        chk("rst_mid_keep", rdat, 32'h55AA55AA);
        chk("rst_mid_lat", 32'(lat), 32'd4);

        // strobe held across two zero-wait transfers
        bus_we = 0; bus_sel = 4'hF; bus_adr = B0 + 8; bus_dat = 32'h0;
        cyc0 = 1; stb0 = 1;
        ackmask = 5'h0;
        d1 = 32'h0; d2 = 32'h0;
        for (int k = 1; k <= 4; k++) begin
            step();
            ackmask[k] = ack0;
            if (k == 1) d1 = dat0;
            if (k == 3) d2 = dat0;
        end
        drop();
        chk("b2b_acks", {27'h0, ackmask}, 32'h0000000A);
        chk("b2b_dat1", d1, 32'hDEADBEEF);
        chk("b2b_dat2", d2, 32'hDEADBEEF);
        quiet(0, 3, seen);
        chk("b2b_quiet", {31'h0, seen}, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wb_slave_ram.md
WB_SLAVE_RAM -- requirements
Module: wb_slave_ram

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h0000_0000, byte address of the first word.
REQ-002 SHALL have parameter DEPTH_WORDS, default 1024, number of 32-bit words (power of two, >=2).
REQ-003 SHALL have parameter WAIT_CYCLES, default 0, extra wait states inserted before the response (0..15).
REQ-004 SHALL have one clock and an asynchronous active-high reset, named as follows:
  clk  input  1  rising-edge clock
  rst_i  input  1  asynchronous reset, active-high
  wb_cyc_i  input  1  bus cycle in progress
  wb_stb_i  input  1  strobe, transfer request
  wb_we_i  input  1  1 = write, 0 = read
  wb_sel_i  input  4  byte lane select, bit n = bits [8n+7:8n]
  wb_adr_i  input  32  byte address
  wb_dat_i  input  32  write data
  wb_dat_o  output  32  read data
  wb_ack_o  output  1  normal termination
  wb_err_o  output  1  error termination
  wb_rty_o  output  1  retry, constant 0

Function
REQ-005 SHALL implement a Wishbone classic slave responder to the load/store master; one transfer outstanding at most.
REQ-006 SHALL use FSM states IDLE, WAIT, RESP; the reset state is IDLE.
REQ-007 IDLE: on a clock edge with wb_cyc_i & wb_stb_i = 1, SHALL latch adr, we, sel, dat and go to WAIT if WAIT_CYCLES>0, else to RESP.
REQ-008 WAIT: a down-counter loaded with WAIT_CYCLES SHALL decrement each cycle; on the edge where it reaches 0 the FSM SHALL go to RESP.
REQ-009 RESP: exactly one of wb_ack_o / wb_err_o SHALL be 1 for exactly one cycle; the next state SHALL be IDLE unconditionally.
REQ-010 Latency: the response cycle SHALL be cycle N+1+WAIT_CYCLES, where N is the cycle in which the request was sampled in IDLE.
REQ-011 Back-to-back: stb still high during the RESP cycle SHALL NOT start a transfer; a request held in the following IDLE cycle SHALL be accepted there.
REQ-012 In range: word index = (adr - BASE_ADDR) >> 2 and 0 <= adr - BASE_ADDR < 4*DEPTH_WORDS.
REQ-013 Error: an out-of-range address or adr[1:0] != 0 SHALL produce wb_err_o instead of wb_ack_o, with no memory update and wb_dat_o = 0.
REQ-014 Write: memory SHALL be updated on the edge entering RESP, only for byte lanes with sel = 1; sel = 4'b0000 SHALL ack with no change.
REQ-015 Read: wb_dat_o SHALL carry the full addressed word during the ack cycle regardless of sel, and SHALL be 0 in all other cycles.
REQ-016 Abort: if wb_cyc_i = 0 in any WAIT cycle, the FSM SHALL return to IDLE on that edge, with no write, ack or err.
REQ-017 Inputs SHALL be ignored in WAIT and RESP except for the wb_cyc_i abort check.
REQ-018 Address arithmetic SHALL be 32-bit unsigned; adr < BASE_ADDR SHALL be out of range (no wrap-around into the array).

Reset
REQ-019 While rst_i = 1: state IDLE, counter 0, wb_ack_o = 0, wb_err_o = 0, wb_dat_o = 0, wb_rty_o = 0, all asynchronously.
REQ-020 Reset mid-transfer SHALL discard the transfer: no ack, no err, no write.
REQ-021 Memory contents SHALL NOT be reset; they are undefined until written.
REQ-022 The first request SHALL be sampled no earlier than the first rising edge after rst_i deasserts.

Verification
REQ-023 WAIT_CYCLES=0: write 32'hDEADBEEF to BASE_ADDR+8 with sel=4'hF, then read the same address -> each ack arrives 1 cycle after the sample and the read returns 32'hDEADBEEF.
REQ-024 Byte lanes: write 32'h11223344 with sel=4'hF, then 32'hAABBCCDD with sel=4'b0101 -> a read returns 32'h11BB33DD.
REQ-025 WAIT_CYCLES=3: read -> ack in cycle N+4, ack high for exactly 1 cycle, wb_dat_o = 0 in cycles N+1..N+3.
REQ-026 Errors: address BASE_ADDR+4*DEPTH_WORDS, address BASE_ADDR-4, and address BASE_ADDR+2 -> wb_err_o pulses once each, no ack, and memory is unchanged when read back.
REQ-027 Abort with WAIT_CYCLES=3: write request, then cyc drops in cycle N+2 -> no ack/err and the old data reads back; repeat with rst_i pulsed in cycle N+2 -> outputs 0 immediately and no write.
REQ-028 Stb held high for 2 transfers at WAIT_CYCLES=0 -> acks in cycles N+1 and N+3, with the second transfer sampled in cycle N+2.
